// File: rtl/crossyroad_game_ctrl.sv
// Frame-level game sequencer: debounces buttons into per-frame move requests, tracks player
// position, score and high score, and drives world-scroll and difficulty selects.
module crossyroad_game_ctrl #(
   parameter int GRID_W        = 10,
   parameter int GRID_H        = 8,
   parameter int ROW_ADV       = 3,
   parameter int MOVE_COOLDOWN = 4,
   parameter int DEATH_FRAMES  = 60
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] move,
   input  logic       frame_tick,
   input  logic       collision,
   output logic [1:0] game_state,
   output logic [3:0] player_col,
   output logic [2:0] player_row,
   output logic [9:0] score,
   output logic [9:0] hi_score,
   output logic       scroll_pulse,
   output logic [1:0] speed_level
);

   localparam int         CD_W       = (MOVE_COOLDOWN < 2) ? 1 : $clog2(MOVE_COOLDOWN + 1);
   localparam logic [3:0] COL_START  = 4'(GRID_W / 2);
   localparam logic [3:0] COL_MAX    = 4'(GRID_W - 1);
   localparam logic [2:0] ROW_START  = 3'(GRID_H - 1);
   localparam logic [2:0] ROW_ADV_L  = 3'(ROW_ADV);
   localparam logic [CD_W-1:0] CD_LOAD = CD_W'(MOVE_COOLDOWN);
   localparam logic [7:0] DEATH_LOAD = 8'(DEATH_FRAMES);
   localparam logic [9:0] SCORE_MAX  = 10'h3FF;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PLAY  = 2'd1,
      S_DYING = 2'd2,
      S_OVER  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [3:0]      sync1_q, sync2_q, prev_q;
   logic [3:0]      pending_q, pending_d;
   logic            hit_q, hit_d;
   logic [3:0]      col_q, col_d;
   logic [2:0]      row_q, row_d;
   logic [9:0]      score_q, score_d;
   logic [9:0]      hi_q, hi_d;
   logic            scroll_q, scroll_d;
   logic [1:0]      speed_q, speed_d;
   logic [CD_W-1:0] cool_q, cool_d;
   logic [7:0]      death_q, death_d;
   logic [3:0]      rise;
   logic [3:0]      pend_eff;
   logic            hit_eff;

   function automatic logic [1:0] speed_of(input logic [9:0] s);
      if (s[9:6] != 4'd0)  return 2'd3;
      else if (s[5])       return 2'd2;
      else if (s[4])       return 2'd1;
      else                 return 2'd0;
   endfunction

   always_comb begin
      // Same-cycle edges and collisions are folded in so they count for this tick.
      rise     = sync2_q & ~prev_q;
      pend_eff = pending_q | rise;
      hit_eff  = hit_q | collision;

      pending_d = frame_tick ? 4'd0 : pend_eff;
      hit_d     = frame_tick ? 1'b0 : hit_eff;
      state_d   = state_q;
      col_d     = col_q;
      row_d     = row_q;
      score_d   = score_q;
      hi_d      = hi_q;
      scroll_d  = 1'b0;
      cool_d    = cool_q;
      death_d   = death_q;

      if (frame_tick) begin
         unique case (state_q)
            S_IDLE: begin
               if (pend_eff != 4'd0) begin
                  state_d = S_PLAY;
                  col_d   = COL_START;
                  row_d   = ROW_START;
                  score_d = 10'd0;
                  cool_d  = '0;
               end
            end
            S_PLAY: begin
               if (hit_eff) begin
                  state_d = S_DYING;
                  death_d = DEATH_LOAD;
               end else if (cool_q != '0) begin
                  cool_d = cool_q - CD_W'(1);
               end else if (pend_eff != 4'd0) begin
                  cool_d = CD_LOAD;
                  if (pend_eff[3]) begin
                     score_d = (score_q == SCORE_MAX) ? score_q : score_q + 10'd1;
                     if (row_q == ROW_ADV_L) scroll_d = 1'b1;
                     else if (row_q != 3'd0) row_d = row_q - 3'd1;
                  end else if (pend_eff[2]) begin
                     if (row_q != ROW_START) row_d = row_q + 3'd1;
                  end else if (pend_eff[1]) begin
                     if (col_q != 4'd0) col_d = col_q - 4'd1;
                  end else begin
                     if (col_q != COL_MAX) col_d = col_q + 4'd1;
                  end
               end
            end
            S_DYING: begin
               death_d = (death_q == 8'd0) ? 8'd0 : death_q - 8'd1;
               if (death_q <= 8'd1) begin
                  state_d = S_OVER;
                  if (score_q > hi_q) hi_d = score_q;
               end
            end
            S_OVER: begin
               if (pend_eff != 4'd0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end

      speed_d = speed_of(score_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= 4'd0;
         sync2_q   <= 4'd0;
         prev_q    <= 4'd0;
         pending_q <= 4'd0;
         hit_q     <= 1'b0;
         state_q   <= S_IDLE;
         col_q     <= COL_START;
         row_q     <= ROW_START;
         score_q   <= 10'd0;
         hi_q      <= 10'd0;
         scroll_q  <= 1'b0;
         speed_q   <= 2'd0;
         cool_q    <= '0;
         death_q   <= 8'd0;
      end else begin
         sync1_q   <= move;
         sync2_q   <= sync1_q;
         prev_q    <= sync2_q;
         pending_q <= pending_d;
         hit_q     <= hit_d;
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         score_q   <= score_d;
         hi_q      <= hi_d;
         scroll_q  <= scroll_d;
         speed_q   <= speed_d;
         cool_q    <= cool_d;
         death_q   <= death_d;
      end
   end

   assign game_state   = state_q;
   assign player_col   = col_q;
   assign player_row   = row_q;
   assign score        = score_q;
   assign hi_score     = hi_q;
   assign scroll_pulse = scroll_q;
   assign speed_level  = speed_q;

endmodule

// File: tb/tb_crossyroad_game_ctrl.sv
// Scoreboard bench for crossyroad_game_ctrl: stimulus queues expected outputs per frame tick,
// a monitor compares them the cycle after each tick (or on an explicit reset check).
module tb_crossyroad_game_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] move = 4'd0;
   logic       frame_tick = 1'b0;
   logic       collision = 1'b0;
   logic [1:0] game_state;
   logic [3:0] player_col;
   logic [2:0] player_row;
   logic [9:0] score;
   logic [9:0] hi_score;
   logic       scroll_pulse;
   logic [1:0] speed_level;

   typedef struct packed {
      logic [1:0] st;
      logic [3:0] col;
      logic [2:0] row;
      logic [9:0] sc;
      logic [9:0] hi;
      logic       scr;
      logic [1:0] spd;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic tick_seen = 1'b0;
   logic chk_now   = 1'b0;

   int e_st, e_col, e_row, e_sc, e_hi;

   crossyroad_game_ctrl dut (
      .clk(clk), .rst_n(rst_n), .move(move), .frame_tick(frame_tick), .collision(collision),
      .game_state(game_state), .player_col(player_col), .player_row(player_row),
      .score(score), .hi_score(hi_score), .scroll_pulse(scroll_pulse), .speed_level(speed_level)
   );

   always #5 clk = ~clk;

   always @(posedge clk) tick_seen <= frame_tick;

   task automatic check(input string nm, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic int exp_speed(input int s);
      if (s < 16)      return 0;
      else if (s < 32) return 1;
      else if (s < 64) return 2;
      else             return 3;
   endfunction

   // Monitor: outputs are due the cycle after a tick; scroll must be low otherwise.
   always @(negedge clk) begin
      exp_t e;
      if (tick_seen || chk_now) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
         end else begin
            e = exp_q.pop_front();
            check("game_state",   int'(game_state),   int'(e.st));
            check("player_col",   int'(player_col),   int'(e.col));
            check("player_row",   int'(player_row),   int'(e.row));
            check("score",        int'(score),        int'(e.sc));
            check("hi_score",     int'(hi_score),     int'(e.hi));
            check("scroll_pulse", int'(scroll_pulse), int'(e.scr));
            check("speed_level",  int'(speed_level),  int'(e.spd));
         end
      end else begin
         check("scroll_idle", int'(scroll_pulse), 0);
      end
   end

   task automatic push_exp(input logic scr);
      exp_t e;
      e.st  = 2'(e_st);
      e.col = 4'(e_col);
      e.row = 3'(e_row);
      e.sc  = 10'(e_sc);
      e.hi  = 10'(e_hi);
      e.scr = scr;
      e.spd = 2'(exp_speed(e_sc));
      exp_q.push_back(e);
   endtask

   task automatic pulse_tick(input logic col);
      @(posedge clk); #1;
      frame_tick = 1'b1;
      collision  = col;
      @(posedge clk); #1;
      frame_tick = 1'b0;
      collision  = 1'b0;
   endtask

   task automatic press(input logic [3:0] b);
      @(posedge clk); #1;
      move = b;
      repeat (4) @(posedge clk);
      #1;
      move = 4'd0;
      repeat (3) @(posedge clk);
   endtask

   task automatic idle_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         push_exp(1'b0);
         pulse_tick(1'b0);
      end
   endtask

   task automatic reset_check();
      e_st = 0; e_col = 5; e_row = 7; e_sc = 0; e_hi = 0;
      push_exp(1'b0);
      chk_now = 1'b1;
      @(negedge clk); #1;
      chk_now = 1'b0;
   endtask

   task automatic up_move();
      logic scr;
      press(4'b1000);
      if (e_sc != 1023) e_sc++;
      scr = (e_row == 3);
      if (!scr) e_row--;
      push_exp(scr);
      pulse_tick(1'b0);
   endtask

   task automatic start_game();
      press(4'b1000);
      e_st = 1; e_col = 5; e_row = 7; e_sc = 0;
      push_exp(1'b0);
      pulse_tick(1'b0);
   endtask

   initial begin
      reset_check();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Start consumes the move; four climbs then a scroll at row 3.
      start_game();
      for (int k = 0; k < 5; k++) begin
         up_move();
         idle_ticks(4);
      end

      // Second up-press lands inside the cooldown and is dropped.
      up_move();
      press(4'b1000);
      push_exp(1'b0);
      pulse_tick(1'b0);
      idle_ticks(3);
      up_move();

      // Asynchronous reset mid-game with score 7.
      @(posedge clk); #1;
      rst_n = 1'b0;
      reset_check();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      start_game();
      press(4'b1010);
      e_sc = 1; e_row = 6;
      push_exp(1'b0);
      pulse_tick(1'b0);
      idle_ticks(4);

      for (int k = 0; k < 5; k++) begin
         press(4'b0010);
         e_col--;
         push_exp(1'b0);
         pulse_tick(1'b0);
         idle_ticks(4);
      end
      // Left at column 0 clamps but still loads the cooldown, so the right is dropped.
      press(4'b0010);
      push_exp(1'b0);
      pulse_tick(1'b0);
      press(4'b0001);
      push_exp(1'b0);
      pulse_tick(1'b0);
      idle_ticks(3);
      press(4'b0001);
      e_col = 1;
      push_exp(1'b0);
      pulse_tick(1'b0);
      idle_ticks(4);

      press(4'b0100);
      e_row = 7;
      push_exp(1'b0);
      pulse_tick(1'b0);
      idle_ticks(4);
      press(4'b0100);
      push_exp(1'b0);
      pulse_tick(1'b0);
      idle_ticks(4);

      // Collision on the tick beats the pending right move.
      press(4'b0001);
      e_st = 2;
      push_exp(1'b0);
      pulse_tick(1'b1);
      idle_ticks(59);
      e_st = 3; e_hi = 1;
      push_exp(1'b0);
      pulse_tick(1'b0);
      idle_ticks(2);

      press(4'b1000);
      e_st = 0;
      push_exp(1'b0);
      pulse_tick(1'b0);

      // Climb through every speed threshold up to score saturation.
      start_game();
      for (int k = 0; k < 1025; k++) begin
         up_move();
         idle_ticks(4);
      end

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      if (exp_q.size() != 0) check("queue_drain", exp_q.size(), 0);
      @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
